and_gate: RTL and testbench
===========================

AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the bit width of x, y, z and z_q.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of rise_cnt.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 x  input  WIDTH  SHALL be operand A.
REQ-006 y  input  WIDTH  SHALL be operand B.
REQ-007 z  output  WIDTH  SHALL be the combinational bitwise AND of x and y.
REQ-008 en  input  1  SHALL be the capture enable for z_q.
REQ-009 clr  input  1  SHALL be the synchronous clear for rise_cnt.
REQ-010 z_q  output  WIDTH  SHALL be the registered AND result.
REQ-011 all_q  output  1  SHALL be the registered AND-reduction of z_q, i.e. high only when every bit of z_q is 1.
REQ-012 rise_cnt  output  CNT_W  SHALL be the saturating count of all_q 0->1 transitions.
REQ-013 The port order SHALL be clk, rst_n, x, y, z, en, clr, z_q, all_q, rise_cnt.

Function
REQ-014 z SHALL equal x & y bit-for-bit at all times, with no clock and no reset dependence, including while rst_n=0.
REQ-015 On each rising clk edge with en=1, z_q SHALL load x & y; with en=0, z_q SHALL hold.
REQ-016 Latency x/y -> z SHALL be 0 cycles; x/y -> z_q SHALL be 1 cycle; x/y -> all_q SHALL be 2 cycles.
REQ-017 On each rising edge, all_q SHALL load &z_q (reduction AND of the current z_q), independent of en.
REQ-018 rise_cnt SHALL increment by 1 on an edge where the next all_q is 1 and the current all_q is 0.
REQ-019 rise_cnt SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-020 clr=1 SHALL set rise_cnt to 0 on the next edge; clr SHALL take priority over a simultaneous increment.
REQ-021 Unknown (X/Z) input bits SHALL not be masked; x=0 SHALL force z=0 regardless of y, per standard AND semantics.

Reset
REQ-022 rst_n=0 SHALL immediately, without waiting for clk, force z_q=0, all_q=0 and rise_cnt=0.
REQ-023 The state SHALL remain at reset values while rst_n=0.
REQ-024 After rst_n deasserts, updates SHALL resume on the first rising clk edge.
REQ-025 Reset deassertion SHALL not by itself count as a rise.
REQ-026 Reset asserted mid-operation SHALL clear all state with no partial update on that cycle.

Verification
REQ-027 Truth table, WIDTH=1, rst_n=0: apply (x,y) = 00, 10, 11, 10, each held 20 ns -> z = 0, 0, 1, 0 with no clock required.
REQ-028 Registered path: en=1; x=y=1 for one edge -> z_q=1 after edge 1 and all_q=1 after edge 2. Then en=0 and x=0 -> z_q holds 1.
REQ-029 Counter: toggle x=y between 1 and 0 three times with en=1 -> rise_cnt=3. Then apply clr and increment together -> rise_cnt=0.
REQ-030 Saturation: CNT_W=2, drive 5 rises -> rise_cnt=3, held.
REQ-031 Async reset: with z_q=1 and rise_cnt=2, pulse rst_n low between edges -> outputs 0 immediately, while z still equals x&y.
REQ-032 Width: WIDTH=8, x=8'hF0, y=8'h3C -> z=8'h30 and all_q=0. With x=y=8'hFF -> all_q=1 two cycles later.

Source files
------------

// File: rtl/and_gate.sv
// and_gate: combinational AND with registered result, AND-reduction flag and saturating rise counter
module and_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] z_q,
    output logic             all_q,
    output logic [CNT_W-1:0] rise_cnt
);
    logic all_d;
    logic rise;
    assign z     = x & y;
    assign all_d = &z_q;
    assign rise  = all_d && !all_q;
    // capture the AND result when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) z_q <= '0;
        else if (en) z_q <= x & y;
    end
    // track whether every bit of the registered result is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) all_q <= 1'b0;
        else all_q <= all_d;
    end
    // count 0->1 transitions of all_q, clear wins, saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rise_cnt <= '0;
        else if (clr) rise_cnt <= '0;
        else if (rise && rise_cnt != {CNT_W{1'b1}}) rise_cnt <= rise_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed table and sequence checks for and_gate in three configurations
module tb_and_gate;
    logic clk;
    logic rst_n;
    logic [0:0] a_x, a_y, a_z, a_zq;
    logic a_en, a_clr, a_all;
    logic [15:0] a_cnt;
    logic [0:0] s_x, s_y, s_z, s_zq;
    logic s_en, s_clr, s_all;
    logic [1:0] s_cnt;
    logic [7:0] w_x, w_y, w_z, w_zq;
    logic w_en, w_clr, w_all;
    logic [15:0] w_cnt;
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } vec_t;
    vec_t tv[5];

    and_gate #(.WIDTH(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .x(a_x), .y(a_y), .z(a_z), .en(a_en),
        .clr(a_clr), .z_q(a_zq), .all_q(a_all), .rise_cnt(a_cnt)
    );
    and_gate #(.WIDTH(1), .CNT_W(2)) u_s (
        .clk(clk), .rst_n(rst_n), .x(s_x), .y(s_y), .z(s_z), .en(s_en),
        .clr(s_clr), .z_q(s_zq), .all_q(s_all), .rise_cnt(s_cnt)
    );
    and_gate #(.WIDTH(8), .CNT_W(16)) u_w (
        .clk(clk), .rst_n(rst_n), .x(w_x), .y(w_y), .z(w_z), .en(w_en),
        .clr(w_clr), .z_q(w_zq), .all_q(w_all), .rise_cnt(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rise_a();
        a_x = 1'b1; a_y = 1'b1;
        step(); step();
        a_x = 1'b0; a_y = 1'b0;
        step(); step();
    endtask

    initial begin
        tv[0] = '{8'h00, 8'h00, 8'h00};
        tv[1] = '{8'h01, 8'h00, 8'h00};
        tv[2] = '{8'hFF, 8'hFF, 8'hFF};
        tv[3] = '{8'hF1, 8'h3C, 8'h30};
        tv[4] = '{8'hAA, 8'h55, 8'h00};
        rst_n = 1'b0;
        a_x = 1'b0; a_y = 1'b0; a_en = 1'b0; a_clr = 1'b0;
        s_x = 1'b0; s_y = 1'b0; s_en = 1'b1; s_clr = 1'b0;
        w_x = 8'h00; w_y = 8'h00; w_en = 1'b1; w_clr = 1'b0;
        #1;
        check("rst_zq", 32'(a_zq), 32'd0);
        check("rst_all", 32'(a_all), 32'd0);
        check("rst_cnt", 32'(a_cnt), 32'd0);
        check("rst_w_zq", 32'(w_zq), 32'd0);
        // combinational truth table while held in reset
        for (int i = 0; i < 5; i++) begin
            a_x = tv[i].x[0]; a_y = tv[i].y[0];
            w_x = tv[i].x; w_y = tv[i].y;
            #20;
            check($sformatf("tt_z1_%0d", i), 32'(a_z), 32'(tv[i].z[0]));
            check($sformatf("tt_z8_%0d", i), 32'(w_z), 32'(tv[i].z));
        end
        check("rst_hold_wzq", 32'(w_zq), 32'd0);
        a_x = 1'b0; a_y = 1'b0; w_x = 8'h00; w_y = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("deassert_all", 32'(a_all), 32'd0);
        check("deassert_cnt", 32'(a_cnt), 32'd0);
        // registered path
        a_en = 1'b1; a_x = 1'b1; a_y = 1'b1;
        step();
        check("reg_zq_e1", 32'(a_zq), 32'd1);
        check("reg_all_e1", 32'(a_all), 32'd0);
        a_en = 1'b0; a_x = 1'b0;
        step();
        check("reg_all_e2", 32'(a_all), 32'd1);
        check("reg_zq_hold", 32'(a_zq), 32'd1);
        check("reg_cnt_e2", 32'(a_cnt), 32'd1);
        // counter
        a_en = 1'b1; a_x = 1'b0; a_y = 1'b0;
        step(); step();
        check("fall_all", 32'(a_all), 32'd0);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_cnt", 32'(a_cnt), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            rise_a();
            check($sformatf("cnt_rise_%0d", k), 32'(a_cnt), 32'(k));
        end
        a_x = 1'b1; a_y = 1'b1;
        step();
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_prio_cnt", 32'(a_cnt), 32'd0);
        check("clr_prio_all", 32'(a_all), 32'd1);
        step();
        check("steady_high_cnt", 32'(a_cnt), 32'd0);
        a_x = 1'b0; a_y = 1'b0;
        step(); step();
        rise_a(); rise_a();
        a_x = 1'b1; a_y = 1'b1;
        step();
        check("pre_rst_zq", 32'(a_zq), 32'd1);
        check("pre_rst_cnt", 32'(a_cnt), 32'd2);
        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_zq", 32'(a_zq), 32'd0);
        check("arst_all", 32'(a_all), 32'd0);
        check("arst_cnt", 32'(a_cnt), 32'd0);
        check("arst_z", 32'(a_z), 32'd1);
        a_x = 1'b0;
        #1;
        check("arst_z_follow", 32'(a_z), 32'd0);
        a_x = 1'b1;
        step();
        check("arst_hold_zq", 32'(a_zq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("resume_zq", 32'(a_zq), 32'd1);
        check("resume_cnt", 32'(a_cnt), 32'd0);
        // saturation with CNT_W=2
        for (int k = 1; k <= 5; k++) begin
            s_x = 1'b1; s_y = 1'b1;
            step(); step();
            s_x = 1'b0; s_y = 1'b0;
            step(); step();
            check($sformatf("sat_%0d", k), 32'(s_cnt), (k > 3) ? 32'd3 : 32'(k));
        end
        step(); step();
        check("sat_held", 32'(s_cnt), 32'd3);
        // width 8
        w_x = 8'hF0; w_y = 8'h3C;
        step(); step();
        check("w_zq", 32'(w_zq), 32'h30);
        check("w_all0", 32'(w_all), 32'd0);
        w_x = 8'hFF; w_y = 8'hFF;
        step();
        check("w_all_e1", 32'(w_all), 32'd0);
        step();
        check("w_all_e2", 32'(w_all), 32'd1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
